audio_looper_multi: RTL and testbench
=====================================

# audio_looper_multi

Parametrised multi-channel audio looper between the audio CODEC read/write data and the CODEC output. Records up to 2^ADDR_W sample frames into on-chip synchronous RAM, then loops them back with selectable playback speed (0.25x–4x), forward or reverse direction, and optional saturating overdub of live input onto the stored loop. Successor to the fixed two-instance looper: one instance serves all channels and owns its own record/play state machine, so no separate button tracker is needed.

## Interface

- DATA_W, 24, signed two's-complement sample width per channel
- ADDR_W, 14, loop memory depth is 2^ADDR_W frames
- N_CH, 2, channel count; channel k occupies bits [k*DATA_W +: DATA_W]

- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  asynchronous, active-high; clears all state
- sample_valid  in  1  one-cycle strobe per sample frame; strobes are ≥3 cycles apart
- in  in  N_CH*DATA_W  live input frame, valid with sample_valid
- rec_btn  in  1  one-cycle pulse (already debounced/edge-cut upstream)
- speed_up  in  1  one-cycle pulse
- slow_down  in  1  one-cycle pulse
- reverse  in  1  level; 1 = play backwards
- overdub  in  1  level; 1 = mix live input into loop during PLAY
- out  out  N_CH*DATA_W  output frame
- out_valid  out  1  one-cycle strobe marking out update
- state  out  2  00 IDLE, 01 RECORD, 10 PLAY
- speed_idx  out  3  0..4 → step 0.25x,0.5x,1x,2x,4x
- loop_len  out  ADDR_W+1  recorded frame count

## Operation

- State machine (transitions evaluated every clk on rec_btn):
  - IDLE --rec_btn--> RECORD; wr_addr←0.
  - RECORD: each sample_valid writes in at wr_addr, wr_addr++. rec_btn → PLAY with loop_len←wr_addr; if wr_addr=0, go to IDLE instead (loop_len=0). Write of frame 2^ADDR_W−1 forces PLAY with loop_len=2^ADDR_W in the same cycle.
  - PLAY --rec_btn--> RECORD (discard loop, wr_addr←0).
- Position pos: fixed-point, 2 fractional bits, range [0, 4*loop_len). On PLAY entry pos←0 if reverse=0, else 4*(loop_len−1). Read address = pos>>2 (zero-order hold).
- Step per sample_valid in PLAY: 1,2,4,8,16 for speed_idx 0..4, clamped to 4*loop_len. Forward: pos+step, subtract 4*loop_len if ≥ 4*loop_len. Reverse: pos−step, add 4*loop_len if negative. Toggling reverse mid-play continues from current pos.
- speed_up/slow_down: saturating inc/dec of speed_idx (bounds 0,4); both in same cycle → no change. Valid in any state.
- Output: IDLE/RECORD → out = in (monitor passthrough). PLAY → out = RAM[pos>>2]; with overdub=1, per channel sum = RAM + in saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1], written back to the same address and driven on out.
- Reset mid-operation: returns to IDLE, loop contents considered invalid (RAM not cleared, loop_len=0).

## Timing

- Reset values: state=IDLE, speed_idx=2, loop_len=0, out=0, out_valid=0, pos=0, wr_addr=0.
- Cycle T = sample_valid: RAM read issued (PLAY) or write (RECORD). T+1: RAM data available, saturation computed. T+2: out registered, out_valid=1 for one cycle; overdub write-back at T+2. pos updates at T+1.
- rec_btn coincident with sample_valid: sample processed under the old state, transition at same edge for the next frame.
- Single-port RAM; ≥3-cycle sample spacing guarantees no read/write-back conflict.

## Test plan

- Reset, rec_btn, 8 frames ramp 1..8, rec_btn → state=PLAY, loop_len=8; next 10 frames out = 1..8,1,2, each out_valid 2 cycles after sample_valid.
- Same loop, reverse=1 at PLAY entry → out = 8,7,…,1,8; toggle reverse after out=5 → next 6,7.
- speed_up ×3 from reset → speed_idx=4 (saturated); 8-frame loop at 4x → out = 1,5,1,5; slow_down ×5 → speed_idx=0, each value held 4 frames.
- Overdub with stored 0x7FFFF0, in=0x20 → out=0x7FFFFF and RAM write-back 0x7FFFFF; stored −5, in=3 → −2.
- ADDR_W=3: record 8 frames without rec_btn → auto PLAY, loop_len=8; rec_btn immediately after entering RECORD → IDLE, loop_len=0.
- Assert reset mid-PLAY asynchronously → outputs to reset values within the same cycle, no out_valid thereafter.

Source files
------------

// File: rtl/audio_looper_multi.sv
// audio_looper_multi
//   Multi-channel audio looper. Records up to 2^ADDR_W frames into a
//   single-port synchronous RAM, then loops them back at 0.25x..4x speed,
//   forwards or backwards, with optional saturating overdub of live input.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high; clears all state (RAM contents kept)
//   sample_valid one-cycle strobe per frame, strobes at least 3 cycles apart
//   in           live frame, channel k at [k*DATA_W +: DATA_W]
//   rec_btn      one-cycle pulse: IDLE->RECORD->PLAY->RECORD ...
//   speed_up     one-cycle pulse, saturating increment of speed_idx
//   slow_down    one-cycle pulse, saturating decrement of speed_idx
//   reverse      level, 1 = play backwards
//   overdub      level, 1 = mix live input into the loop during PLAY
//   out          output frame (passthrough in IDLE/RECORD, loop in PLAY)
//   out_valid    one-cycle strobe, two cycles after the sample_valid it answers
//   state        00 IDLE, 01 RECORD, 10 PLAY
//   speed_idx    0..4 -> 0.25x, 0.5x, 1x, 2x, 4x
//   loop_len     recorded frame count
module audio_looper_multi #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 14,
  parameter int N_CH   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic [N_CH*DATA_W-1:0]   in,
  input  logic                     rec_btn,
  input  logic                     speed_up,
  input  logic                     slow_down,
  input  logic                     reverse,
  input  logic                     overdub,
  output logic [N_CH*DATA_W-1:0]   out,
  output logic                     out_valid,
  output logic [1:0]               state,
  output logic [2:0]               speed_idx,
  output logic [ADDR_W:0]          loop_len
);

  localparam int FW    = N_CH * DATA_W;
  localparam int PW    = ADDR_W + 3;   // pos holds 4*frames, up to 4*2^ADDR_W
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RECORD = 2'b01,
    PLAY   = 2'b10
  } state_t;

  state_t          cur_st, nxt_st;
  logic [ADDR_W:0] wr_addr, wr_addr_nxt, loop_len_nxt, wr_count;
  logic [PW-1:0]   pos, pos_nxt;
  logic            play_first, first_nxt;

  // ---------------------------------------------------------------------------
  // Playback position arithmetic
  // ---------------------------------------------------------------------------
  logic          rec_wr, play_rd, last_frame;
  logic [PW-1:0] len4, step_raw, step, pos_fwd, pos_rev, pos_step, rd_pos;
  logic [PW:0]   fwd_sum, fwd_wrap;

  assign rec_wr     = (cur_st == RECORD) && sample_valid;
  assign play_rd    = (cur_st == PLAY) && sample_valid;
  assign wr_count   = wr_addr + {{ADDR_W{1'b0}}, rec_wr};
  assign last_frame = rec_wr && (wr_addr == (ADDR_W+1)'(DEPTH - 1));

  assign len4     = {loop_len, 2'b00};
  assign step_raw = PW'(1) << speed_idx;
  assign step     = (step_raw > len4) ? len4 : step_raw;

  // pos < len4 and step <= len4, so a single wrap correction is enough.
  assign fwd_sum  = {1'b0, pos} + {1'b0, step};
  assign fwd_wrap = fwd_sum - {1'b0, len4};
  assign pos_fwd  = (fwd_sum >= {1'b0, len4}) ? fwd_wrap[PW-1:0] : fwd_sum[PW-1:0];
  assign pos_rev  = (pos >= step) ? (pos - step) : (pos + len4 - step);
  assign pos_step = reverse ? pos_rev : pos_fwd;

  // The first frame after entering PLAY reads the entry position itself;
  // later frames step first and read the new position, so a direction
  // change takes effect on the very next frame.
  assign rd_pos = play_first ? pos : pos_step;

  // ---------------------------------------------------------------------------
  // Record / play state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      cur_st     <= IDLE;
      wr_addr    <= '0;
      loop_len   <= '0;
      pos        <= '0;
      play_first <= 1'b0;
    end else begin
      cur_st     <= nxt_st;
      wr_addr    <= wr_addr_nxt;
      loop_len   <= loop_len_nxt;
      pos        <= pos_nxt;
      play_first <= first_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    nxt_st       = cur_st;
    wr_addr_nxt  = wr_addr;
    loop_len_nxt = loop_len;
    pos_nxt      = pos;
    first_nxt    = play_first;
    unique case (cur_st)
      IDLE: begin
        if (rec_btn) begin
          nxt_st      = RECORD;
          wr_addr_nxt = '0;
        end
      end
      RECORD: begin
        wr_addr_nxt = wr_count;
        // A frame written in the same cycle as rec_btn belongs to the loop.
        if (last_frame || (rec_btn && (wr_count != '0))) begin
          nxt_st       = PLAY;
          loop_len_nxt = wr_count;
          first_nxt    = 1'b1;
          pos_nxt      = reverse ? ({wr_count, 2'b00} - PW'(4)) : '0;
        end else if (rec_btn) begin
          nxt_st       = IDLE;
          loop_len_nxt = '0;
        end
      end
      PLAY: begin
        if (play_rd) begin
          pos_nxt   = rd_pos;
          first_nxt = 1'b0;
        end
        if (rec_btn) begin
          nxt_st       = RECORD;
          wr_addr_nxt  = '0;
          loop_len_nxt = '0;
        end
      end
      default: nxt_st = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Speed selection
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      speed_idx <= 3'd2;
    end else if (speed_up && !slow_down && (speed_idx != 3'd4)) begin
      speed_idx <= speed_idx + 3'd1;
    end else if (slow_down && !speed_up && (speed_idx != 3'd0)) begin
      speed_idx <= speed_idx - 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Loop memory (single port). Overdub write-back lands two cycles after the
  // read; strobe spacing keeps it clear of the next frame's access.
  // ---------------------------------------------------------------------------
  logic [FW-1:0]     mem [DEPTH];
  logic [FW-1:0]     rd_data, ram_wdata, mix;
  logic [ADDR_W-1:0] ram_addr, s1_addr, wb_addr;
  logic              ram_we, wb_pending;

  assign ram_we    = wb_pending || rec_wr;
  assign ram_wdata = wb_pending ? out : in;
  assign ram_addr  = wb_pending           ? wb_addr :
                     (cur_st == RECORD)   ? wr_addr[ADDR_W-1:0] :
                                            rd_pos[ADDR_W+1:2];

  // NOTE: the memory array is deliberately not reset; a reset only
  // invalidates the loop through loop_len.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rd_data <= mem[ram_addr];
  end

  // ---------------------------------------------------------------------------
  // Output pipeline: T issue, T+1 data + saturation, T+2 out / write-back
  // ---------------------------------------------------------------------------
  logic          s1_valid, s1_play, s1_mix;
  logic [FW-1:0] s1_in;

  for (genvar k = 0; k < N_CH; k++) begin : g_sat
    logic signed [DATA_W:0] sum;
    assign sum = $signed({rd_data[k*DATA_W+DATA_W-1], rd_data[k*DATA_W +: DATA_W]})
               + $signed({s1_in[k*DATA_W+DATA_W-1],   s1_in[k*DATA_W +: DATA_W]});
    // Overflow when the extended sign differs from the result sign.
    assign mix[k*DATA_W +: DATA_W] = (sum[DATA_W] != sum[DATA_W-1])
                                   ? {sum[DATA_W], {(DATA_W-1){~sum[DATA_W]}}}
                                   : sum[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_play    <= 1'b0;
      s1_mix     <= 1'b0;
      s1_addr    <= '0;
      s1_in      <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      wb_pending <= 1'b0;
      wb_addr    <= '0;
    end else begin
      s1_valid   <= sample_valid;
      s1_play    <= play_rd;
      s1_mix     <= play_rd && overdub;
      s1_addr    <= rd_pos[ADDR_W+1:2];
      if (sample_valid) s1_in <= in;
      out_valid  <= s1_valid;
      if (s1_valid) out <= s1_play ? (s1_mix ? mix : rd_data) : s1_in;
      wb_pending <= s1_mix;
      wb_addr    <= s1_addr;
    end
  end

  assign state = cur_st;

endmodule

// File: tb/tb_audio_looper_multi.sv
// Self-checking bench for audio_looper_multi. Every sample_valid pushes the
// hand-computed expected frame and its due cycle onto a queue; a monitor pops
// and compares whenever out_valid is seen. A second instance with ADDR_W=3
// exercises the full-memory auto-stop.
module tb_audio_looper_multi;

  localparam int DW = 24;
  localparam int NC = 2;
  localparam int FW = DW * NC;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_valid;
  logic [FW-1:0] in_a;
  logic          rec_btn, rec_btn_b, speed_up, slow_down, reverse, overdub;

  logic [FW-1:0] out_a, out_b;
  logic          out_valid_a, out_valid_b;
  logic [1:0]    state_a, state_b;
  logic [2:0]    speed_a, speed_b;
  logic [14:0]   len_a;
  logic [3:0]    len_b;

  audio_looper_multi #(.DATA_W(DW), .ADDR_W(14), .N_CH(NC)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .in(in_a),
    .rec_btn(rec_btn), .speed_up(speed_up), .slow_down(slow_down),
    .reverse(reverse), .overdub(overdub), .out(out_a), .out_valid(out_valid_a),
    .state(state_a), .speed_idx(speed_a), .loop_len(len_a)
  );

  audio_looper_multi #(.DATA_W(DW), .ADDR_W(3), .N_CH(NC)) dut_b (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .in(in_a),
    .rec_btn(rec_btn_b), .speed_up(speed_up), .slow_down(slow_down),
    .reverse(reverse), .overdub(overdub), .out(out_b), .out_valid(out_valid_b),
    .state(state_b), .speed_idx(speed_b), .loop_len(len_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] data;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor on the opposite edge.
  exp_t e_m;
  always @(negedge clk) begin
    if (out_valid_a) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out_valid got=%h at cycle %0d, none expected", out_a, cyc);
      end else begin
        e_m = exp_q.pop_front();
        if (out_a !== e_m.data || cyc != e_m.due) begin
          n_err++;
          $display("FAIL sb_out got=%h at cycle %0d, expected %h at cycle %0d",
                   out_a, cyc, e_m.data, e_m.due);
        end
      end
    end
  end

  function automatic logic [FW-1:0] mk(input int c1, input int c0);
    logic [31:0] a, b;
    a = c1;
    b = c0;
    return {a[DW-1:0], b[DW-1:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One frame strobe with its expected output; returns 3 cycles after issue.
  task automatic frame(input logic [FW-1:0] d, input logic [FW-1:0] e);
    exp_t x;
    x.data = e;
    x.due  = cyc + 2;
    exp_q.push_back(x);
    in_a = d;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic press_rec();
    rec_btn = 1'b1;
    @(posedge clk); #1;
    rec_btn = 1'b0;
  endtask

  task automatic press_rec_b();
    rec_btn_b = 1'b1;
    @(posedge clk); #1;
    rec_btn_b = 1'b0;
  endtask

  task automatic press_speed(input logic up, input logic down);
    speed_up  = up;
    slow_down = down;
    @(posedge clk); #1;
    speed_up  = 1'b0;
    slow_down = 1'b0;
  endtask

  task automatic record_ramp();
    for (int k = 1; k <= 8; k++) frame(mk(-k, k), mk(-k, k));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  int rev_seq[12] = '{8, 7, 6, 5, 4, 3, 2, 1, 8, 7, 6, 5};
  int slow_seq[8] = '{5, 5, 5, 6, 6, 6, 6, 7};
  int v;

  initial begin
    reset = 1'b1;
    sample_valid = 1'b0; in_a = '0;
    rec_btn = 1'b0; rec_btn_b = 1'b0; speed_up = 1'b0; slow_down = 1'b0;
    reverse = 1'b0; overdub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state",     state_a,     0);
    check("rst_speed",     speed_a,     2);
    check("rst_loop_len",  len_a,       0);
    check("rst_out",       out_a,       0);
    check("rst_out_valid", out_valid_a, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Forward loop at 1x, passthrough while recording.
    press_rec();
    check("enter_record", state_a, 1);
    record_ramp();
    press_rec();
    check("enter_play", state_a, 2);
    check("loop_len_8", len_a, 8);
    for (int i = 0; i < 10; i++) begin
      v = (i % 8) + 1;
      frame(mk(32'h55, 32'h55), mk(-v, v));
    end

    // Reverse from PLAY entry, then switch to forward mid-loop.
    press_rec();
    check("rerecord", state_a, 1);
    record_ramp();
    reverse = 1'b1;
    press_rec();
    check("rev_play", state_a, 2);
    for (int i = 0; i < 12; i++) frame(mk(0, 0), mk(-rev_seq[i], rev_seq[i]));
    reverse = 1'b0;
    frame(mk(0, 0), mk(-6, 6));
    frame(mk(0, 0), mk(-7, 7));

    // Speed saturation and playback rates.
    do_reset();
    for (int i = 0; i < 3; i++) press_speed(1'b1, 1'b0);
    check("speed_max", speed_a, 4);
    press_speed(1'b1, 1'b0);
    check("speed_sat_hi", speed_a, 4);
    press_rec();
    record_ramp();
    press_rec();
    for (int i = 0; i < 4; i++) begin
      v = (i % 2 == 0) ? 1 : 5;
      frame(mk(0, 0), mk(-v, v));
    end
    for (int i = 0; i < 5; i++) press_speed(1'b0, 1'b1);
    check("speed_sat_lo", speed_a, 0);
    press_speed(1'b1, 1'b1);
    check("speed_both_lo", speed_a, 0);
    for (int i = 0; i < 8; i++) frame(mk(0, 0), mk(-slow_seq[i], slow_seq[i]));
    press_speed(1'b1, 1'b0);
    press_speed(1'b1, 1'b1);
    check("speed_both_mid", speed_a, 1);
    press_speed(1'b1, 1'b0);
    check("speed_back_1x", speed_a, 2);

    // Overdub with saturation and write-back.
    press_rec();
    frame(mk(-5, 32'h7FFFF0), mk(-5, 32'h7FFFF0));
    frame(mk(32'h100, 32'h800000), mk(32'h100, 32'h800000));
    press_rec();
    check("od_loop_len", len_a, 2);
    overdub = 1'b1;
    frame(mk(3, 32'h20), mk(-2, 32'h7FFFFF));
    frame(mk(1, -1), mk(32'h101, 32'h800000));
    overdub = 1'b0;
    frame(mk(9, 9), mk(-2, 32'h7FFFFF));
    frame(mk(9, 9), mk(32'h101, 32'h800000));

    // Full-memory auto stop on the 8-frame instance.
    do_reset();
    press_rec_b();
    check("b_record", state_b, 1);
    for (int k = 1; k <= 7; k++) frame(mk(k, k), mk(k, k));
    check("b_still_record", state_b, 1);
    frame(mk(8, 8), mk(8, 8));
    check("b_auto_play", state_b, 2);
    check("b_loop_len_8", len_b, 8);
    press_rec_b();
    check("b_rerecord", state_b, 1);
    press_rec_b();
    check("b_empty_idle", state_b, 0);
    check("b_empty_len", len_b, 0);

    // Asynchronous reset mid-PLAY with a frame in flight.
    press_rec();
    for (int k = 1; k <= 3; k++) frame(mk(k, k), mk(k, k));
    press_rec();
    check("pre_reset_play", state_a, 2);
    press_speed(1'b1, 1'b0);
    in_a = mk(1, 1);
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_state",     state_a,     0);
    check("arst_speed",     speed_a,     2);
    check("arst_loop_len",  len_a,       0);
    check("arst_out",       out_a,       0);
    check("arst_out_valid", out_valid_a, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("post_reset_idle", state_a, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
